// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: D-stage operand/producer info in, forward selects and stall out
interface hazard_fwd_ctrl_if;
  logic       flush;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic [4:0] dst_d;
  logic [1:0] tnew_d;
  logic       pc8_d;
  logic [1:0] md_op_d;
  logic [2:0] forward_src_rs;
  logic [2:0] forward_src_rt;
  logic       stall;
  modport master (
    output flush, rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d, pc8_d, md_op_d,
    input  forward_src_rs, forward_src_rt, stall
  );
  modport slave (
    input  flush, rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d, pc8_d, md_op_d,
    output forward_src_rs, forward_src_rt, stall
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: D-stage Tnew/Tuse scoreboard, forward selects and mul/div stall.
// Define HAZARD_W_BYPASS_EN to forward W-stage matches as WD instead of RD.
module hazard_fwd_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic             clk,
  input logic             reset,
  hazard_fwd_ctrl_if.slave h
);
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       pc8;
  } entry_t;
  localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
`ifdef HAZARD_W_BYPASS_EN
  localparam logic [2:0] W_CODE = 3'd4;
`else
  localparam logic [2:0] W_CODE = 3'd0;
`endif
  entry_t          e_q, e_d, m_q, m_d;
  logic [4:0]      w_dst_q, w_dst_d;
  logic            md_e_q, md_e_d, md_div_q, md_div_d;
  logic [CW-1:0]   busy_q, busy_d;
  logic [3:0]      rs_r, rt_r;
  logic            stall_raw;
  // Returns {stall, select} for one operand; youngest matching entry decides.
  function automatic logic [3:0] resolve(input logic [4:0] a, input logic [1:0] tuse,
                                         input entry_t e, input entry_t m, input logic [4:0] w_dst);
    logic       he, hm, hw;
    logic [1:0] tn;
    he = a != 5'd0 && e.dst == a;
    hm = a != 5'd0 && m.dst == a;
    hw = a != 5'd0 && w_dst == a;
    tn = he ? e.tnew : hm ? m.tnew : 2'd0;
    return {tuse != 2'd3 && tuse < tn,
            he ? (e.tnew == 2'd0 && e.pc8 ? 3'd1 : 3'd0) :
            hm ? (m.tnew == 2'd0 ? (m.pc8 ? 3'd3 : 3'd2) : 3'd0) :
            hw ? W_CODE : 3'd0};
  endfunction
  always_comb begin
    rs_r      = resolve(h.rs_d, h.tuse_rs_d, e_q, m_q, w_dst_q);
    rt_r      = resolve(h.rt_d, h.tuse_rt_d, e_q, m_q, w_dst_q);
    stall_raw = rs_r[3] | rt_r[3] | ((md_e_q || busy_q != '0) && h.md_op_d != 2'd0);
    w_dst_d   = m_q.dst;
    m_d       = entry_t'{dst: e_q.dst, tnew: e_q.tnew == 2'd0 ? 2'd0 : e_q.tnew - 2'd1, pc8: e_q.pc8};
    e_d       = stall_raw ? entry_t'('0) : entry_t'{dst: h.dst_d, tnew: h.tnew_d, pc8: h.pc8_d};
    md_e_d    = !stall_raw && (h.md_op_d == 2'd1 || h.md_op_d == 2'd2);
    md_div_d  = !stall_raw && h.md_op_d == 2'd2;
    busy_d    = md_e_q ? (md_div_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
                busy_q != '0 ? busy_q - CW'(1) : busy_q;
  end
  // Reset masks outputs at once so a reset mid-divide releases the stall immediately.
  assign h.stall          = !reset && stall_raw;
  assign h.forward_src_rs = reset ? 3'd0 : rs_r[2:0];
  assign h.forward_src_rt = reset ? 3'd0 : rt_r[2:0];
  always_ff @(posedge clk) begin
    if (reset || h.flush) begin
      e_q      <= '0;
      m_q      <= '0;
      w_dst_q  <= '0;
      md_e_q   <= 1'b0;
      md_div_q <= 1'b0;
      busy_q   <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_dst_q  <= w_dst_d;
      md_e_q   <= md_e_d;
      md_div_q <= md_div_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: scenario tasks with a queue of expected {stall, rs_sel, rt_sel}
module tb_hazard_fwd_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;
`ifdef HAZARD_W_BYPASS_EN
  localparam logic [2:0] WC = 3'd4;
`else
  localparam logic [2:0] WC = 3'd0;
`endif
  typedef struct packed {
    logic       rst;
    logic       fl;
    logic [4:0] rs;
    logic [1:0] urs;
    logic [4:0] rt;
    logic [1:0] urt;
    logic [4:0] dst;
    logic [1:0] tn;
    logic       p8;
    logic [1:0] md;
    logic [6:0] exp;
  } step_t;
  logic [6:0] sb[$];
  hazard_fwd_ctrl_if h();
  hazard_fwd_ctrl dut (.clk(clk), .reset(reset), .h(h));
  always #5 clk = ~clk;
  function automatic step_t mk(input logic rst, input logic fl, input logic [4:0] rs, input logic [1:0] urs,
                               input logic [4:0] rt, input logic [1:0] urt, input logic [4:0] dst,
                               input logic [1:0] tn, input logic p8, input logic [1:0] md,
                               input logic est, input logic [2:0] ers, input logic [2:0] ert);
    return '{rst: rst, fl: fl, rs: rs, urs: urs, rt: rt, urt: urt, dst: dst, tn: tn, p8: p8, md: md,
             exp: {est, ers, ert}};
  endfunction
  task automatic apply(input step_t s);
    @(negedge clk);
    reset = s.rst; h.flush = s.fl; h.rs_d = s.rs; h.tuse_rs_d = s.urs; h.rt_d = s.rt;
    h.tuse_rt_d = s.urt; h.dst_d = s.dst; h.tnew_d = s.tn; h.pc8_d = s.p8; h.md_op_d = s.md;
    sb.push_back(s.exp);
  endtask
  task automatic drain();
    @(negedge clk);
    reset = 1'b0; h.flush = 1'b1; h.rs_d = 0; h.tuse_rs_d = 3; h.rt_d = 0; h.tuse_rt_d = 3;
    h.dst_d = 0; h.tnew_d = 0; h.pc8_d = 0; h.md_op_d = 0;
  endtask
  task automatic test_reset();
    step_t s[$];
    logic [6:0] e, got;
    s.push_back(mk(1, 0, 5, 0, 5, 0, 5, 1, 0, 2, 0, 0, 0));
    s.push_back(mk(1, 0, 5, 0, 5, 0, 5, 1, 0, 3, 0, 0, 0));
    s.push_back(mk(0, 0, 5, 0, 5, 0, 0, 0, 0, 3, 0, 0, 0));
    s.push_back(mk(0, 0, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      #2 e = sb.pop_front();
      got = {h.stall, h.forward_src_rs, h.forward_src_rt};
      checks++;
      if (got !== e) $display("FAIL reset step%0d got stall=%0d rs=%0d rt=%0d expected stall=%0d rs=%0d rt=%0d",
                              i, got[6], got[5:3], got[2:0], e[6], e[5:3], e[2:0]);
      else passed++;
    end
  endtask
  task automatic test_alu_load();
    step_t s[$];
    logic [6:0] e, got;
    s.push_back(mk(0, 0, 0, 3, 0, 3, 8, 1, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 8, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 8, 0, 0, 3, 0, 0, 0, 0, 0, 2, 0));
    s.push_back(mk(0, 0, 8, 0, 0, 3, 0, 0, 0, 0, 0, WC, 0));
    s.push_back(mk(0, 1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 3, 0, 3, 9, 2, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 3, 9, 1, 10, 1, 0, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 3, 9, 1, 10, 1, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 10, 1, 9, 1, 0, 0, 0, 0, 0, 0, WC));
    s.push_back(mk(0, 0, 10, 0, 10, 0, 0, 0, 0, 0, 0, 2, 2));
    foreach (s[i]) begin
      apply(s[i]);
      #2 e = sb.pop_front();
      got = {h.stall, h.forward_src_rs, h.forward_src_rt};
      checks++;
      if (got !== e) $display("FAIL alu_load step%0d got stall=%0d rs=%0d rt=%0d expected stall=%0d rs=%0d rt=%0d",
                              i, got[6], got[5:3], got[2:0], e[6], e[5:3], e[2:0]);
      else passed++;
    end
  endtask
  task automatic test_link_zero();
    step_t s[$];
    logic [6:0] e, got;
    s.push_back(mk(0, 0, 0, 3, 0, 3, 31, 0, 1, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 31, 0, 31, 3, 0, 0, 0, 0, 0, 1, 1));
    s.push_back(mk(0, 0, 31, 0, 31, 3, 0, 0, 0, 0, 0, 3, 3));
    s.push_back(mk(0, 0, 31, 0, 0, 3, 0, 2, 0, 0, 0, WC, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      #2 e = sb.pop_front();
      got = {h.stall, h.forward_src_rs, h.forward_src_rt};
      checks++;
      if (got !== e) $display("FAIL link_zero step%0d got stall=%0d rs=%0d rt=%0d expected stall=%0d rs=%0d rt=%0d",
                              i, got[6], got[5:3], got[2:0], e[6], e[5:3], e[2:0]);
      else passed++;
    end
  endtask
  task automatic test_back_to_back();
    step_t s[$];
    logic [6:0] e, got;
    s.push_back(mk(0, 0, 0, 3, 0, 3, 9, 2, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 3, 9, 0, 0, 0, 0, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 3, 9, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      #2 e = sb.pop_front();
      got = {h.stall, h.forward_src_rs, h.forward_src_rt};
      checks++;
      if (got !== e) $display("FAIL flush_stall step%0d got stall=%0d rs=%0d rt=%0d expected stall=%0d rs=%0d rt=%0d",
                              i, got[6], got[5:3], got[2:0], e[6], e[5:3], e[2:0]);
      else passed++;
    end
  endtask
  task automatic test_muldiv(input int mode);
    step_t s[$];
    logic [6:0] e, got;
    case (mode)
      0: begin
        s.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 2, 0, 0, 0));
        for (int k = 0; k < 12; k++) s.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 3, k < 11, 0, 0));
      end
      1: begin
        s.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 2, 0, 0, 0));
        for (int k = 0; k < 4; k++) s.push_back(mk(0, k == 3, 0, 3, 0, 3, 0, 0, 0, 3, 1, 0, 0));
        s.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 3, 0, 0, 0));
      end
      2: begin
        s.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < 7; k++) s.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 1, k < 6, 0, 0));
      end
      default: begin
        s.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 2, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 3, 1, 0, 0));
        s.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 3, 1, 0, 0));
        s.push_back(mk(1, 0, 0, 3, 0, 3, 0, 0, 0, 3, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 3, 0, 0, 0));
      end
    endcase
    foreach (s[i]) begin
      apply(s[i]);
      #2 e = sb.pop_front();
      got = {h.stall, h.forward_src_rs, h.forward_src_rt};
      checks++;
      if (got !== e) $display("FAIL muldiv%0d step%0d got stall=%0d rs=%0d rt=%0d expected stall=%0d rs=%0d rt=%0d",
                              mode, i, got[6], got[5:3], got[2:0], e[6], e[5:3], e[2:0]);
      else passed++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    test_reset();
    drain();
    test_alu_load();
    drain();
    test_link_zero();
    drain();
    test_back_to_back();
    for (int m = 0; m < 4; m++) begin
      drain();
      test_muldiv(m);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- D-stage hazard and forwarding controller for the 5-stage MIPS pipeline; produces the `forward_src_rs` / `forward_src_rt` select codes that drive the D-stage forwarding mux, plus the D-stage stall.
- Holds a registered scoreboard of in-flight destinations (E, M, W entries) with per-entry Tnew countdown.
- Tracks the multiply/divide unit busy window.
- Cleared by pipeline flush on exception/eret.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu enters E
- DIV_CYCLES, 10, busy cycles after a div/divu enters E

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  exception/eret flush; clears scoreboard and E bubble next edge
- rs_d  in  5  D-stage rs address
- rt_d  in  5  D-stage rt address
- tuse_rs_d  in  2  cycles until rs is needed (0=D, 1=E, 2=M, 3=unused)
- tuse_rt_d  in  2  same for rt
- dst_d  in  5  D-stage write register (0 = no write)
- tnew_d  in  2  Tnew at E entry (0=jal/PC8, 1=ALU, 2=load)
- pc8_d  in  1  result is PC+8 (link instruction)
- md_op_d  in  2  0=none, 1=mult start, 2=div start, 3=hi/lo access (mfhi/mflo/mthi/mtlo)
- forward_src_rs  out  3  rs select code
- forward_src_rt  out  3  rt select code
- stall  out  1  freeze PC and F/D, bubble into E

Behaviour:
- Select codes, fixed: 0=RD (regfile), 1=PC4E (PC4_E+4), 2=AO (M-stage ALU out), 3=PC4M (PC4_M+4), 4=WD (W write data); codes 5-7 never driven.
- Entry fields: dst[4:0], tnew[1:0], pc8. An entry with dst=0 is empty.
- Register update each rising clk edge, priority top-down:
  - reset or flush: E, M and W entries cleared (dst=0, tnew=0); md_e=0; busy_cnt=0.
  - else: W<=M.
  - M<=E, with tnew saturating decrement (max(E.tnew-1,0)).
  - E<= stall ? empty : {dst_d, tnew_d, pc8_d}.
  - md_e<= stall ? 0 : (md_op_d==1 or 2).
  - Multiply/divide counter: if md_e is set, busy_cnt loads MULT_CYCLES or DIV_CYCLES (op type latched with md_e); otherwise busy_cnt decrements when nonzero.
  - E-entry tnew is stored as the E-stage value; the W entry always has tnew=0.
- Operand match (evaluated separately for rs and rt, address a):
  - Matching requires a!=0 and entry.dst==a.
  - Youngest match wins: E over M over W.
- Forward code (combinational from registered entries and D inputs):
  - E match, tnew=0, pc8 -> PC4E.
  - M match, tnew=0: pc8 -> PC4M, else AO.
  - W match -> WD.
  - No match, or the youngest match not yet ready -> RD.
- Stall (combinational): asserted if, for rs or rt with tuse!=3, the youngest matching entry has tuse < tnew.
  - Also asserted if md_op_d==3 and (md_e or busy_cnt!=0).
  - Also asserted if md_op_d is 1 or 2 and (md_e or busy_cnt!=0).
- The forward code is still driven during stall; it is don't-care to the pipeline.
- Boundaries:
  - Same register in rs and rt: both selects are identical.
  - Flush coincident with stall: flush wins.
  - busy_cnt never wraps below 0.
  - Reset mid-divide drops the busy window immediately.
- Reset values: all state 0. With all entries empty and busy_cnt=0, outputs are select=RD and stall=0 for any D input.
- Latency: scoreboard advances 1 stage per cycle; outputs are valid the same cycle as D inputs.

Optional Feature:
- Macro: HAZARD_W_BYPASS_EN.
- Defined: a W-stage match yields WD (code 4).
- Undefined: a W-stage match yields RD (code 0), because the register file does write-before-read internally; code 4 is never produced.
- Stall logic is unaffected by the macro.

Test Plan:
- Reset held 2 cycles, any inputs, e.g. rs_d=5 -> selects 0, stall 0 while reset high and on the first cycle after release.
- `addu $8` (dst 8, tnew 1) then `beq $8,$0` (tuse_rs 0) -> stall=1 for 1 cycle; next cycle forward_src_rs=2 (AO), stall 0.
- `lw $9` (tnew 2) then `addu` using $9 as rt with tuse 1 -> stall 1 for 1 cycle; then the load is in M with tnew 1 and E is a bubble, so no stall (tuse 1 ≥ tnew 1) and forward_src_rt=0 (RD) while the load is in M; the load's data then arrives through the E-stage mux.
- `jal` (dst 31, tnew 0, pc8) then `jr $31` (tuse 0) -> forward_src_rs=1 with no stall; with a nop between them -> forward_src_rs=3.
- `div` enters E, then `mflo` in D -> stall held 11 cycles (md_e plus DIV_CYCLES=10), released when busy_cnt reaches 0; flush at cycle 4 -> stall drops the next cycle.
- Producer to $0 (dst 0) followed by a consumer of $0 -> select 0 and stall 0; a W-stage match gives code 4 with HAZARD_W_BYPASS_EN defined and code 0 without it.
